write_select_stage: RTL and testbench

WRITE_SELECT_STAGE -- requirements
Module: write_select_stage

---
 rtl/write_select_stage.sv | 93 +++++++++
 tb/tb_write_select_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/write_select_stage.sv
// Registered channel selector with valid/ready handshake and illegal-select substitution.
// Optional saturating illegal-select counter enabled by defining WSS_ERRCNT_EN.
module write_select_stage #(
    parameter int                 WIDTH       = 32,
    parameter int                 NUM_IN      = 8,
    parameter int                 SEL_W       = 4,
    parameter logic [WIDTH-1:0]   DEFAULT_VAL = WIDTH'(227)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_keep,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              err_count,
    input  logic                    err_clr
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [SEL_W-1:0] last_sel;
    logic [SEL_W-1:0] eff_sel;
    logic             sel_legal;
    logic [WIDTH-1:0] sel_data;
    logic             accept;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign eff_sel   = sel_keep ? last_sel : sel;
    assign sel_legal = (32'(eff_sel) < NUM_IN);

    // Explicit compare-per-channel mux so an out-of-range selector falls back to DEFAULT_VAL, never X.
    always_comb begin
        sel_data = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(eff_sel) == k) begin
                sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            out_err  <= 1'b0;
            last_sel <= '0;
        end else begin
            if (accept) begin
                state    <= FULL;
                out_data <= sel_data;
                out_sel  <= eff_sel;
                out_err  <= !sel_legal;
                last_sel <= eff_sel;
            end else if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

`ifdef WSS_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Clear takes priority over a same-cycle increment; the count sticks at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (err_clr) begin
            err_cnt_q <= 8'd0;
        end else if (accept && !sel_legal && err_cnt_q != 8'd255) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_count      = 8'd0;
`endif

endmodule

// File: tb/tb_write_select_stage.sv
// Randomized and directed bench for write_select_stage with a transaction-level reference model.
module tb_write_select_stage;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 6;
    localparam int SEL_W  = 4;

    logic                    clk;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]        sel;
    logic                    sel_keep;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              err_count;
    logic                    err_clr;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] chan [NUM_IN];

    // Reference model state: the item currently presented downstream plus remembered selector.
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_sel;
    bit               m_err;
    int               m_last;
    int               m_cnt;

    write_select_stage #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .sel      (sel),
        .sel_keep (sel_keep),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_err  (out_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_count(err_count),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_valid = 0;
        m_data  = '0;
        m_sel   = 0;
        m_err   = 0;
        m_last  = 0;
        m_cnt   = 0;
    endtask

    task automatic checkState();
        checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            checkOutput("out_data", 64'(out_data), 64'(m_data));
            checkOutput("out_sel", 64'(out_sel), 64'(m_sel));
            checkOutput("out_err", 64'(out_err), 64'(m_err));
        end
        checkOutput("err_count", 64'(err_count), 64'(m_cnt));
    endtask

    // One clock of stimulus: drive, check ready before the edge, advance model, check after the edge.
    task automatic applyStimulus(input bit iv, input bit keep, input int s, input bit ordy, input bit clr);
        bit accept;
        int eff;
        for (int k = 0; k < NUM_IN; k++) data_in[k*WIDTH +: WIDTH] = chan[k];
        in_valid  = iv;
        sel_keep  = keep;
        sel       = SEL_W'(s);
        out_ready = ordy;
        err_clr   = clr;
        @(negedge clk);
        checkOutput("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
        @(posedge clk);
        accept = iv && (!m_valid || ordy);
        if (accept) begin
            eff     = keep ? m_last : s;
            m_last  = eff;
            m_sel   = eff;
            m_valid = 1;
            if (eff < NUM_IN) begin
                m_data = chan[eff];
                m_err  = 0;
            end else begin
                m_data = 227;
                m_err  = 1;
            end
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
`ifdef WSS_ERRCNT_EN
        if (clr) m_cnt = 0;
        else if (accept && m_err && m_cnt < 255) m_cnt = m_cnt + 1;
`endif
        #1;
        checkState();
    endtask

    task automatic randomChannels();
        for (int k = 0; k < NUM_IN; k++) chan[k] = $urandom;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelReset();
        for (int k = 0; k < NUM_IN; k++) chan[k] = WIDTH'(32'h1000 + k);
        data_in   = '0;
        sel       = '0;
        sel_keep  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        reset     = 1'b1;
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_sel", 64'(out_sel), 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Basic select of channel 3
        chan[3] = 32'h0000ABCD;
        applyStimulus(1, 0, 3, 1, 0);
        checkOutput("sel3_data", 64'(out_data), 64'h0000ABCD);

        // Illegal selectors 6 and 7
        applyStimulus(1, 0, 6, 1, 0);
        checkOutput("sel6_data", 64'(out_data), 64'd227);
        applyStimulus(1, 0, 7, 1, 0);
        checkOutput("sel7_err", 64'(out_err), 64'd1);

        // Stall: accept, then hold with changing inputs, then release with no bubble
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            randomChannels();
            applyStimulus(1, 0, $urandom_range(0, 15), 0, 0);
        end
        randomChannels();
        applyStimulus(1, 0, 4, 1, 0);
        checkOutput("no_bubble_valid", 64'(out_valid), 64'd1);

        // Selector reuse
        applyStimulus(1, 0, 2, 1, 0);
        applyStimulus(1, 1, 5, 1, 0);
        checkOutput("keep_sel", 64'(out_sel), 64'd2);
        checkOutput("keep_data", 64'(out_data), 64'(chan[2]));

        // Saturation then clear colliding with an illegal accept
        for (int i = 0; i < 260; i++) applyStimulus(1, 0, $urandom_range(6, 15), 1, 0);
        applyStimulus(1, 0, 9, 1, 1);
        applyStimulus(0, 0, 0, 1, 0);

        // Asynchronous reset during a stall
        applyStimulus(1, 0, 3, 0, 0);
        applyStimulus(1, 0, 8, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_ready", 64'(in_ready), 64'd1);
        checkOutput("async_rst_data", 64'(out_data), 64'd0);
        checkOutput("async_rst_cnt", 64'(err_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        randomChannels();
        applyStimulus(1, 1, 11, 1, 0);
        checkOutput("last_sel_after_rst", 64'(out_sel), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomChannels();
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 15), $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
